if_stage: RTL and testbench

- Instruction-fetch stage of the 16-bit pipeline. Owns the PC and issues word-addressed requests to instruction memory, which has variable latency.
- Delivers {instr, pc} through an IF/ID output register that has a one-entry skid buffer.
- Consumes the execute stage's redirect (PCSrc, targetAddr) and stops fetching once a HLT has been delivered.
- pc_out is the instruction's own address; the execute stage computes pc + offset + 1 from it.

---
 rtl/if_stage_pkg.sv | 26 ++
 rtl/if_stage_if.sv | 26 ++
 rtl/if_skid_buf.sv | 30 +++
 rtl/if_stage.sv | 146 ++++++++++++++
 tb/tb_if_stage.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

    localparam int unsigned XLEN   = 16;
    localparam int unsigned OP_W   = 4;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    // Fetch state machine encoding.
    typedef enum logic [1:0] {
        IF_REQ  = 2'd0,
        IF_WAIT = 2'd1,
        IF_FULL = 2'd2,
        IF_HALT = 2'd3
    } ifState_t;

    // Fetched instruction together with its own address.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetchPkt_t;

    function automatic logic isHalt(input logic [XLEN-1:0] instr);
        return instr[XLEN-1 -: OP_W] == OP_HLT;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: memory request/response, IF/ID output and control inputs.
interface if_stage_if;
    import if_stage_pkg::*;

    logic            stall;
    logic            PCSrc;
    logic [XLEN-1:0] targetAddr;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_valid;
    logic [XLEN-1:0] imem_data;
    logic [XLEN-1:0] instr_out;
    logic [XLEN-1:0] pc_out;
    logic            valid_out;
    logic            halted;

    modport master (
        input  stall, PCSrc, targetAddr, imem_valid, imem_data,
        output imem_req, imem_addr, instr_out, pc_out, valid_out, halted
    );

    modport slave (
        output stall, PCSrc, targetAddr, imem_valid, imem_data,
        input  imem_req, imem_addr, instr_out, pc_out, valid_out, halted
    );
endinterface

// File: rtl/if_skid_buf.sv
// One-entry skid buffer holding a fetched {pc, instr} the output could not take.
module if_skid_buf
    import if_stage_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load,
    input  logic      drain,
    input  logic      flush,
    input  fetchPkt_t dataIn,
    output logic      full,
    output fetchPkt_t dataOut
);

    // Flush wins over load; load and drain never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            full    <= 1'b0;
            dataOut <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            full    <= 1'b1;
            dataOut <= dataIn;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, request FSM, IF/ID output register with skid.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 16'h0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 16'h0000
) (
    input  logic clk,
    input  logic rst,
    if_stage_if.master bus
);

    ifState_t        state, stateNext;
    logic [XLEN-1:0] pc, pcNext;
    logic            drop, dropNext;
    logic            outValid;
    logic [XLEN-1:0] outInstr, outPc;
    logic            haltedQ;
    logic            skidFull;
    fetchPkt_t       skidData;
    logic            respOk, outFree, loadOut, loadSkid, drainSkid;

    // Response acceptance and where it lands.
    always_comb begin
        respOk    = (state == IF_WAIT) && bus.imem_valid && !drop && !bus.PCSrc;
        outFree   = !outValid || !bus.stall;
        loadOut   = respOk && outFree;
        loadSkid  = respOk && !outFree;
        drainSkid = ((state == IF_FULL) || (state == IF_HALT)) && skidFull
                    && !bus.stall && !bus.PCSrc;
    end

    // Next state, next PC and drop flag; redirect takes precedence.
    always_comb begin
        stateNext = state;
        pcNext    = pc;
        dropNext  = drop;
        if (bus.PCSrc) begin
            pcNext = bus.targetAddr;
            case (state)
                IF_REQ: begin
                    dropNext  = 1'b1;
                    stateNext = IF_WAIT;
                end
                IF_WAIT: begin
                    if (bus.imem_valid) begin
                        dropNext  = 1'b0;
                        stateNext = IF_REQ;
                    end else begin
                        dropNext  = 1'b1;
                    end
                end
                default: stateNext = IF_REQ;
            endcase
        end else begin
            case (state)
                IF_REQ:  stateNext = IF_WAIT;
                IF_WAIT: begin
                    if (bus.imem_valid) begin
                        if (drop) begin
                            dropNext  = 1'b0;
                            stateNext = IF_REQ;
                        end else begin
                            pcNext = pc + XLEN'(1);
                            if (isHalt(bus.imem_data))
                                stateNext = IF_HALT;
                            else if (!outFree)
                                stateNext = IF_FULL;
                            else
                                stateNext = IF_REQ;
                        end
                    end
                end
                IF_FULL: begin
                    if (!bus.stall)
                        stateNext = IF_REQ;
                end
                default: stateNext = IF_HALT;
            endcase
        end
    end

    // State, PC and drop registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IF_REQ;
            pc    <= RESET_PC;
            drop  <= 1'b0;
        end else begin
            state <= stateNext;
            pc    <= pcNext;
            drop  <= dropNext;
        end
    end

    // IF/ID output register: flush, load, drain from skid, consume or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            outValid <= 1'b0;
            outInstr <= NOP_INSTR;
            outPc    <= '0;
        end else if (bus.PCSrc) begin
            outValid <= 1'b0;
            outInstr <= NOP_INSTR;
        end else if (loadOut) begin
            outValid <= 1'b1;
            outInstr <= bus.imem_data;
            outPc    <= pc;
        end else if (drainSkid) begin
            outValid <= 1'b1;
            outInstr <= skidData.instr;
            outPc    <= skidData.pc;
        end else if (outValid && !bus.stall) begin
            outValid <= 1'b0;
            outInstr <= NOP_INSTR;
        end
    end

    // Halted flag tracks entry into and exit from HALT.
    always_ff @(posedge clk) begin
        if (rst)
            haltedQ <= 1'b0;
        else
            haltedQ <= (stateNext == IF_HALT);
    end

    if_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (loadSkid),
        .drain   (drainSkid),
        .flush   (bus.PCSrc),
        .dataIn  ('{pc: pc, instr: bus.imem_data}),
        .full    (skidFull),
        .dataOut (skidData)
    );

    // Request strobe is a decode of the state register so it lines up with pc.
    assign bus.imem_req  = (state == IF_REQ) && !rst;
    assign bus.imem_addr = pc;
    assign bus.instr_out = outInstr;
    assign bus.pc_out    = outPc;
    assign bus.valid_out = outValid;
    assign bus.halted    = haltedQ;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage with a variable-latency memory model.
module tb_if_stage;
    import if_stage_pkg::*;

    logic clk;
    logic rst;
    if_stage_if bus ();

    if_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    int memLat     = 1;
    fetchPkt_t sb[$];
    logic [15:0] memArr [logic [15:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] memRead(input logic [15:0] a);
        if (memArr.exists(a)) return memArr[a];
        return {4'h1, a[11:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expectPkt(input logic [15:0] instr, input logic [15:0] pc);
        fetchPkt_t p;
        p.instr = instr;
        p.pc    = pc;
        sb.push_back(p);
    endtask

    // Waits (bounded) for the next request strobe and checks its address.
    task automatic nextReq(input string name, input logic [15:0] expAddr, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.imem_req) seen = 1'b1;
        end
        if (seen) check(name, 32'(bus.imem_addr), 32'(expAddr));
        else begin
            compared++;
            mismatched++;
            $display("FAIL %s: no request within %0d cycles, expected addr %h", name, budget, expAddr);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instruction memory: one response per request after memLat cycles.
    always begin
        @(negedge clk);
        if (!rst && bus.imem_req) begin
            logic [15:0] a;
            a = bus.imem_addr;
            repeat (memLat) @(posedge clk);
            #1;
            bus.imem_valid = 1'b1;
            bus.imem_data  = memRead(a);
            @(posedge clk);
            #1;
            bus.imem_valid = 1'b0;
        end
    end

    // Monitor: every consumed output must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.valid_out && !bus.stall) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_output: got instr %h pc %h, expected nothing", bus.instr_out, bus.pc_out);
            end else begin
                fetchPkt_t e;
                e = sb.pop_front();
                check("output_pkt", {bus.pc_out, bus.instr_out}, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.stall      = 1'b0;
        bus.PCSrc      = 1'b0;
        bus.targetAddr = 16'h0000;
        bus.imem_valid = 1'b0;
        bus.imem_data  = 16'h0000;
        memArr[16'h0000] = 16'h1234;
        memArr[16'h0001] = 16'hAAAA;
        memArr[16'h0002] = 16'hBEEF;
        memArr[16'h0040] = 16'hF000;
        memArr[16'h0011] = 16'hDEAD;
        memArr[16'hFFFF] = 16'h7777;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid",  32'(bus.valid_out), 32'd0);
        check("rst_instr",  32'(bus.instr_out), 32'h0);
        check("rst_pc",     32'(bus.pc_out),    32'h0);
        check("rst_halted", 32'(bus.halted),    32'd0);
        check("rst_req",    32'(bus.imem_req),  32'd0);

        // First fetch, then stall while the second response lands in the skid.
        expectPkt(16'h1234, 16'h0000);
        @(posedge clk);
        #1 rst = 1'b0;
        nextReq("req_addr0", 16'h0000, 4);
        tick();
        tick();
        bus.stall = 1'b1;
        @(negedge clk);
        check("first_valid", 32'(bus.valid_out), 32'd1);
        check("first_instr", 32'(bus.instr_out), 32'h1234);
        check("first_pc",    32'(bus.pc_out),    32'h0);
        check("req1_strobe", 32'(bus.imem_req),  32'd1);
        check("req1_addr",   32'(bus.imem_addr), 32'h1);
        @(negedge clk);
        @(negedge clk);
        check("full_hold_instr", 32'(bus.instr_out), 32'h1234);
        check("full_hold_valid", 32'(bus.valid_out), 32'd1);
        check("full_no_req",     32'(bus.imem_req),  32'd0);
        @(negedge clk);
        check("full_no_req2",    32'(bus.imem_req),  32'd0);
        tick();
        bus.stall = 1'b0;
        memLat    = 3;
        expectPkt(16'hAAAA, 16'h0001);
        nextReq("req_after_drain", 16'h0002, 4);
        check("skid_out_instr", 32'(bus.instr_out), 32'hAAAA);

        // Redirect while waiting; the late 16'hBEEF must be dropped.
        tick();
        bus.PCSrc      = 1'b1;
        bus.targetAddr = 16'h0040;
        tick();
        bus.PCSrc = 1'b0;
        memLat    = 1;
        check("flush_valid", 32'(bus.valid_out), 32'd0);
        expectPkt(16'hF000, 16'h0040);
        nextReq("redirect_addr", 16'h0040, 8);
        check("drop_valid", 32'(bus.valid_out), 32'd0);

        // HLT delivery stops fetching until a redirect.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("hlt_instr",  32'(bus.instr_out), 32'hF000);
        check("hlt_halted", 32'(bus.halted),    32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("halt_no_req", 32'(bus.imem_req), 32'd0);
            check("halt_flag",   32'(bus.halted),   32'd1);
        end
        tick();
        bus.PCSrc      = 1'b1;
        bus.targetAddr = 16'h0010;
        tick();
        bus.PCSrc = 1'b0;
        expectPkt(16'h1010, 16'h0010);
        nextReq("unhalt_addr", 16'h0010, 4);
        check("unhalt_flag", 32'(bus.halted), 32'd0);

        // Redirect in REQ to 16'hFFFF; the in-flight 16'h0011 fetch is dropped.
        tick();
        tick();
        bus.PCSrc      = 1'b1;
        bus.targetAddr = 16'hFFFF;
        tick();
        bus.PCSrc = 1'b0;
        expectPkt(16'h7777, 16'hFFFF);
        nextReq("addr_ffff", 16'hFFFF, 8);
        nextReq("wrap_addr", 16'h0000, 6);

        // Fill the skid, then reset.
        tick();
        bus.stall = 1'b1;
        tick();
        tick();
        tick();
        @(negedge clk);
        check("pre_rst_no_req", 32'(bus.imem_req),  32'd0);
        check("pre_rst_instr",  32'(bus.instr_out), 32'h1234);
        tick();
        rst = 1'b1;
        sb.delete();
        tick();
        rst       = 1'b0;
        bus.stall = 1'b0;
        expectPkt(16'h1234, 16'h0000);
        expectPkt(16'hAAAA, 16'h0001);
        @(negedge clk);
        check("post_rst_valid",  32'(bus.valid_out), 32'd0);
        check("post_rst_instr",  32'(bus.instr_out), 32'h0);
        check("post_rst_halted", 32'(bus.halted),    32'd0);
        check("post_rst_req",    32'(bus.imem_req),  32'd1);
        check("post_rst_addr",   32'(bus.imem_addr), 32'h0);
        nextReq("post_rst_addr1", 16'h0001, 4);
        nextReq("post_rst_addr2", 16'h0002, 4);
        tick();
        bus.stall = 1'b1;
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
